// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk: receives MSB-first bytes onto a parallel bus
// with a one-cycle strobe and shifts out a parallel-loaded byte. Nothing is clocked by sck.
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] mdata,
  input  logic [7:0] sdata,
  output logic       data_valid_read,
  output logic       data_firstbyte
);

  logic       sck_m_q, sck_s_q, sck_h_q;
  logic       cs_m_q, cs_s_q, cs_h_q;
  logic       mosi_m_q, mosi_s_q;
  logic [2:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] mdata_q, mdata_d;
  logic       vld_q, vld_d;
  logic       fb_q, fb_d;
  logic       miso_q, miso_d;

  logic sel, cs_fall, cs_rise, sck_rise, sck_fall;

  assign sel      = ~cs_s_q;
  assign cs_fall  = cs_h_q & ~cs_s_q;
  assign cs_rise  = ~cs_h_q & cs_s_q;
  assign sck_rise = sck_s_q & ~sck_h_q;
  assign sck_fall = ~sck_s_q & sck_h_q;

  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    mdata_d = mdata_q;
    vld_d   = 1'b0;
    fb_d    = 1'b0;
    if (cs_fall) begin
      cnt_d   = 3'd0;
      first_d = 1'b1;
      tx_d    = sdata;
    end else if (cs_rise) begin
      // A partial byte is simply abandoned: rx contents never reach mdata.
      cnt_d = 3'd0;
    end else if (sel && sck_rise) begin
      rx_d  = {rx_q[6:0], mosi_s_q};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        mdata_d = rx_d;
        vld_d   = 1'b1;
        fb_d    = first_q;
        first_d = 1'b0;
      end
    end else if (sel && sck_fall) begin
      // Counter at zero on a falling edge marks a byte boundary: fetch the next byte.
      tx_d = (cnt_q != 3'd0) ? {tx_q[6:0], 1'b0} : sdata;
    end
    // miso follows the next TX state so it lands on the same edge as the shift/load.
    miso_d = sel & tx_d[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_m_q  <= 1'b0;
      sck_s_q  <= 1'b0;
      sck_h_q  <= 1'b0;
      cs_m_q   <= 1'b0;
      cs_s_q   <= 1'b0;
      cs_h_q   <= 1'b0;
      mosi_m_q <= 1'b0;
      mosi_s_q <= 1'b0;
      cnt_q    <= 3'd0;
      first_q  <= 1'b0;
      rx_q     <= 8'h00;
      tx_q     <= 8'h00;
      mdata_q  <= 8'h00;
      vld_q    <= 1'b0;
      fb_q     <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      sck_m_q  <= sck;
      sck_s_q  <= sck_m_q;
      sck_h_q  <= sck_s_q;
      cs_m_q   <= cs;
      cs_s_q   <= cs_m_q;
      cs_h_q   <= cs_s_q;
      mosi_m_q <= mosi;
      mosi_s_q <= mosi_m_q;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      mdata_q  <= mdata_d;
      vld_q    <= vld_d;
      fb_q     <= fb_d;
      miso_q   <= miso_d;
    end
  end

  assign miso            = miso_q;
  assign mdata           = mdata_q;
  assign data_valid_read = vld_q;
  assign data_firstbyte  = fb_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master plus a strobe scoreboard that checks
// received byte, first-byte flag and strobe cycle.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst, sck, cs, mosi;
  logic       miso;
  logic [7:0] mdata;
  logic [7:0] sdata;
  logic       data_valid_read, data_firstbyte;

  typedef struct {
    logic [7:0] data;
    logic       first;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  spi_slave dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .mdata(mdata), .sdata(sdata), .data_valid_read(data_valid_read),
    .data_firstbyte(data_firstbyte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the oldest expected byte and its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid_read === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe got mdata=%h first=%b at cyc=%0d required no strobe",
                   mdata, data_firstbyte, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mdata !== mon_e.data || data_firstbyte !== mon_e.first || cyc !== mon_e.cyc) begin
            bad++;
            $display("FAIL strobe got mdata=%h first=%b cyc=%0d required mdata=%h first=%b cyc=%0d",
                     mdata, data_firstbyte, cyc, mon_e.data, mon_e.first, mon_e.cyc);
          end
        end
      end else if (data_firstbyte !== 1'b0 || data_valid_read !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL idle_flags got valid=%b first=%b required 0 0", data_valid_read, data_firstbyte);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1);
  end

  // Drives bits hi..lo of mo, 4 clk per sck phase; returns miso sampled before each rise.
  task automatic xfer(input logic [7:0] mo, input int hi, input int lo,
                      input logic first, input bit push, output logic [7:0] mi);
    exp_t e;
    mi = 8'h00;
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      mosi = mo[i];
      repeat (3) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      if (i == 0 && push) begin
        e.data  = mo;
        e.first = first;
        e.cyc   = cyc + 3;
        sb.push_back(e);
      end
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic select_slave();
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic deselect_slave();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending strobes required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0; sck = 1'b0; mosi = 1'b1; sdata = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({miso, mdata, data_valid_read, data_firstbyte} !== 11'd0) begin
        bad++;
        $display("FAIL reset_outputs got miso=%b mdata=%h valid=%b first=%b required all 0",
                 miso, mdata, data_valid_read, data_firstbyte);
      end
      sck = ~sck;
      @(negedge clk);
    end
    cs = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] mi;
    sdata = 8'h8A;
    select_slave();
    xfer(8'hA5, 7, 0, 1'b1, 1'b1, mi);
    total++;
    if (mi !== 8'h8A) begin
      bad++;
      $display("FAIL single_miso got %h required 8a", mi);
    end
    deselect_slave();
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    sdata = 8'h96;
    select_slave();
    xfer(8'h3C, 7, 0, 1'b1, 1'b1, mi1);
    sdata = 8'h55;
    xfer(8'hC3, 7, 0, 1'b0, 1'b1, mi2);
    total++;
    if (mi1 !== 8'h96) begin
      bad++;
      $display("FAIL burst_miso0 got %h required 96", mi1);
    end
    total++;
    if (mi2 !== 8'h55) begin
      bad++;
      $display("FAIL burst_miso1 got %h required 55", mi2);
    end
    deselect_slave();
    check_drained("burst");
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    sdata = 8'h5A;
    select_slave();
    xfer(8'hE7, 7, 3, 1'b0, 1'b0, mi);
    deselect_slave();
    total++;
    if (mdata !== 8'hC3) begin
      bad++;
      $display("FAIL abort_mdata_kept got %h required c3", mdata);
    end
    select_slave();
    xfer(8'h0F, 7, 0, 1'b1, 1'b1, mi);
    total++;
    if (mi !== 8'h5A) begin
      bad++;
      $display("FAIL abort_next_miso got %h required 5a", mi);
    end
    deselect_slave();
    check_drained("abort");
  endtask

  task automatic test_deselected();
    logic       miso_seen;
    sdata = 8'hFF;
    miso_seen = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mosi = i[0];
      sck = 1'b1;
      repeat (4) @(negedge clk);
      miso_seen = miso_seen | miso;
      sck = 1'b0;
      repeat (3) @(negedge clk);
      miso_seen = miso_seen | miso;
    end
    total++;
    if (miso_seen !== 1'b0) begin
      bad++;
      $display("FAIL deselect_miso got %b required 0", miso_seen);
    end
    total++;
    if (mdata !== 8'h0F) begin
      bad++;
      $display("FAIL deselect_mdata got %h required 0f", mdata);
    end
    repeat (6) @(negedge clk);
    check_drained("deselect");
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] mi;
    sdata = 8'hFF;
    select_slave();
    xfer(8'hB6, 7, 4, 1'b0, 1'b0, mi);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    xfer(8'hB6, 3, 0, 1'b0, 1'b0, mi);
    repeat (6) @(negedge clk);
    total++;
    if (mdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_mdata got %h required 00", mdata);
    end
    deselect_slave();
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_deselected();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
